// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
// Widths, FSM/port encodings, error word and the latched request record.
package mem_port_arbiter_pkg;

    localparam int ADDRESS_WIDTH     = 32;
    localparam int DATA_WIDTH        = 32;
    localparam int DEF_MAX_DM_STREAK = 4;
    localparam int DEF_TIMEOUT       = 64;

    localparam logic [DATA_WIDTH-1:0] DEADBEEF_WORD = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_DM = 1'b1
    } port_id_e;

    typedef struct packed {
        logic                     we;
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    wdata;
    } mem_req_t;

    function automatic logic is_misaligned(input logic [ADDRESS_WIDTH-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/arb_priority_select.sv
// Winner selection between fetch and data ports: data first, except that a
// pending, unhalted fetch is forced through once the data streak saturates.
module arb_priority_select #(
    parameter int STREAK_W      = 3,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic                i_dm_req,
    input  logic                i_if_req,
    input  logic                i_halt,
    input  logic [STREAK_W-1:0] i_streak,
    output logic                o_grant_if,
    output logic                o_grant_dm
);

    logic w_streak_full;

    assign w_streak_full = (i_streak == STREAK_W'(MAX_DM_STREAK));
    assign o_grant_if    = i_if_req & ~i_halt & (~i_dm_req | w_streak_full);
    assign o_grant_dm    = i_dm_req & ~o_grant_if;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data stages: one transaction at a
// time, registered response pulse, timeout/misalignment reported as err.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     halt_signal,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    output logic                     if_stall,
    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [ADDRESS_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]    dm_wdata,
    output logic                     dm_gnt,
    output logic                     dm_rvalid,
    output logic [DATA_WIDTH-1:0]    dm_rdata,
    output logic                     dm_stall,
    output logic                     err,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic                     mem_ack,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
    localparam int TO_W     = $clog2(TIMEOUT);

    arb_state_e          r_state, w_state_next;
    port_id_e            r_port;
    mem_req_t            r_req, w_sel_req;
    logic [DATA_WIDTH-1:0] r_data;
    logic                r_err;
    logic [STREAK_W-1:0] r_streak;
    logic [TO_W-1:0]     r_timeout;

    logic w_grant_if, w_grant_dm, w_start, w_misaligned, w_timeout_hit;

    arb_priority_select #(
        .STREAK_W      (STREAK_W),
        .MAX_DM_STREAK (MAX_DM_STREAK)
    ) u_select (
        .i_dm_req   (dm_req),
        .i_if_req   (if_req),
        .i_halt     (halt_signal),
        .i_streak   (r_streak),
        .o_grant_if (w_grant_if),
        .o_grant_dm (w_grant_dm)
    );

    always_comb begin
        w_sel_req = '0;
        if (w_grant_dm) begin
            w_sel_req.we    = dm_we;
            w_sel_req.addr  = dm_addr;
            w_sel_req.wdata = dm_wdata;
        end else begin
            w_sel_req.addr  = if_addr;
        end
    end

    assign w_start       = (r_state == IDLE) & (w_grant_if | w_grant_dm);
    assign w_misaligned  = is_misaligned(w_sel_req.addr);
    assign w_timeout_hit = (r_timeout == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_next = w_misaligned ? RESP : ACCESS;
            ACCESS:  if (mem_ack || w_timeout_hit) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Grants are combinational, so they are masked while reset is held low.
    always_comb begin
        if_gnt    = w_start & w_grant_if & rst;
        dm_gnt    = w_start & w_grant_dm & rst;
        mem_req   = (r_state == ACCESS);
        mem_we    = mem_req & r_req.we;
        mem_addr  = mem_req ? r_req.addr  : '0;
        mem_wdata = mem_req ? r_req.wdata : '0;
        if_rvalid = (r_state == RESP) & (r_port == PORT_IF);
        dm_rvalid = (r_state == RESP) & (r_port == PORT_DM);
        err       = (r_state == RESP) & r_err;
        if_rdata  = if_rvalid ? r_data : '0;
        dm_rdata  = dm_rvalid ? r_data : '0;
    end

    assign if_stall = if_req & ~if_rvalid;
    assign dm_stall = dm_req & ~dm_rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_port    <= PORT_IF;
            r_req     <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
            r_streak  <= '0;
            r_timeout <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_req     <= w_sel_req;
                        r_timeout <= '0;
                        r_err     <= w_misaligned;
                        r_data    <= w_misaligned ? DEADBEEF_WORD : '0;
                        if (w_grant_dm) begin
                            r_port <= PORT_DM;
                            // Saturate so a halted fetch cannot wrap the streak.
                            if (!if_req)
                                r_streak <= '0;
                            else if (r_streak != STREAK_W'(MAX_DM_STREAK))
                                r_streak <= r_streak + 1'b1;
                        end else begin
                            r_port   <= PORT_IF;
                            r_streak <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        r_data <= r_req.we ? '0 : mem_rdata;
                        r_err  <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_data <= DEADBEEF_WORD;
                        r_err  <= 1'b1;
                    end else begin
                        r_timeout <= r_timeout + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
